// File: rtl/avg_iq_pkg.sv
// Shared definitions for the avgIQ averager: control-word field map, FSM
// state encoding and accumulator width derivation.
package avg_iq_pkg;

  localparam int START_BIT = 31;
  localparam int L_HI      = 19;
  localparam int L_LO      = 16;
  localparam int CHAN_HI   = 8;
  localparam int CHAN_LO   = 0;
  localparam int L_FIELD_W = L_HI - L_LO + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACCUM     = 2'd2,
    DONE      = 2'd3
  } avg_state_e;

  // Room for 2^max_l full-scale samples without overflow.
  function automatic int sum_width(input int data_w, input int max_l);
    return data_w + max_l;
  endfunction

endpackage

// File: rtl/avg_iq_acc.sv
// One signed accumulator lane (I or Q): running sum plus the floor-shifted
// average of the sum including the sample currently presented.
module avg_iq_acc
  import avg_iq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_L  = 12,
  parameter int SUM_W  = sum_width(DATA_W, MAX_L)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  input  logic [L_FIELD_W-1:0]     shift,
  output logic signed [DATA_W-1:0] avg_nxt
);

  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] sum_nxt_s;
  logic signed [SUM_W-1:0] shifted_s;
  logic                    unused_hi_s;

  assign sum_nxt_s   = sum_r + {{(SUM_W-DATA_W){din[DATA_W-1]}}, din};
  // Arithmetic shift gives floor division for negative sums.
  assign shifted_s   = sum_nxt_s >>> shift;
  assign avg_nxt     = shifted_s[DATA_W-1:0];
  assign unused_hi_s = ^shifted_s[SUM_W-1:DATA_W];

  // Running sum: cleared on restart, extended by each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (clr) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (en) begin
      sum_r <= sum_nxt_s;
    end
  end

endmodule

// File: rtl/avg_iq_accum.sv
// Averages 2^L samples of one selected channelizer channel, started by a
// rising edge on the control word start bit; result held for readback.
module avg_iq_accum
  import avg_iq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NCHAN_LOG2 = 9,
  parameter int MAX_L      = 12
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [31:0]              ctrl,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     in_valid,
  input  logic                     in_sync,
  output logic signed [DATA_W-1:0] avg_i,
  output logic signed [DATA_W-1:0] avg_q,
  output logic                     busy,
  output logic                     done,
  output logic                     done_pulse
);

  localparam int SUM_W = sum_width(DATA_W, MAX_L);
  localparam int CNT_W = MAX_L + 1;
  localparam logic [L_FIELD_W-1:0]  MAX_L_F  = L_FIELD_W'(MAX_L);
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NCHAN_LOG2-1:0] CHAN_ONE = {{(NCHAN_LOG2-1){1'b0}}, 1'b1};

  avg_state_e               state_r;
  avg_state_e               state_nxt_s;
  logic                     start_d_r;
  logic                     go_s;
  logic [NCHAN_LOG2-1:0]    chan_cnt_r;
  logic [NCHAN_LOG2-1:0]    cur_chan_s;
  logic [NCHAN_LOG2-1:0]    chan_sel_r;
  logic [L_FIELD_W-1:0]     l_r;
  logic [L_FIELD_W-1:0]     l_field_s;
  logic [L_FIELD_W-1:0]     l_clamp_s;
  logic [CNT_W-1:0]         samp_cnt_r;
  logic [CNT_W-1:0]         samp_last_s;
  logic                     match_s;
  logic                     acc_en_s;
  logic                     last_s;
  logic signed [DATA_W-1:0] avg_i_nxt_s;
  logic signed [DATA_W-1:0] avg_q_nxt_s;
  logic signed [DATA_W-1:0] avg_i_r;
  logic signed [DATA_W-1:0] avg_q_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     done_pulse_r;
  logic                     unused_ctrl_s;

  assign go_s          = ctrl[START_BIT] & ~start_d_r;
  assign l_field_s     = ctrl[L_HI:L_LO];
  assign l_clamp_s     = (l_field_s > MAX_L_F) ? MAX_L_F : l_field_s;
  assign cur_chan_s    = in_sync ? {NCHAN_LOG2{1'b0}} : chan_cnt_r;
  assign match_s       = in_valid & (cur_chan_s == chan_sel_r);
  assign samp_last_s   = (CNT_ONE << l_r) - CNT_ONE;
  assign last_s        = acc_en_s & (samp_cnt_r == samp_last_s);
  assign unused_ctrl_s = ^{ctrl[START_BIT-1:L_HI+1], ctrl[L_LO-1:CHAN_LO+NCHAN_LOG2]};

  // Accept a sample only once aligned to a frame; a restart in the same cycle discards it.
  always_comb begin
    acc_en_s = 1'b0;
    if (go_s) begin
      acc_en_s = 1'b0;
    end else begin
      case (state_r)
        WAIT_SYNC: acc_en_s = match_s & in_sync;
        ACCUM:     acc_en_s = match_s;
        default:   acc_en_s = 1'b0;
      endcase
    end
  end

  // Next-state logic; a start edge restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (go_s) begin
      state_nxt_s = WAIT_SYNC;
    end else begin
      case (state_r)
        IDLE:      state_nxt_s = IDLE;
        WAIT_SYNC: begin
          if (in_valid & in_sync) begin
            state_nxt_s = last_s ? DONE : ACCUM;
          end else begin
            state_nxt_s = WAIT_SYNC;
          end
        end
        ACCUM:     state_nxt_s = last_s ? DONE : ACCUM;
        DONE:      state_nxt_s = DONE;
        default:   state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Edge detect, channel/sample counters, result and status registers.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      start_d_r    <= 1'b0;
      chan_cnt_r   <= {NCHAN_LOG2{1'b0}};
      chan_sel_r   <= {NCHAN_LOG2{1'b0}};
      l_r          <= {L_FIELD_W{1'b0}};
      samp_cnt_r   <= {CNT_W{1'b0}};
      avg_i_r      <= {DATA_W{1'b0}};
      avg_q_r      <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      start_d_r <= ctrl[START_BIT];
      if (in_valid) begin
        chan_cnt_r <= cur_chan_s + CHAN_ONE;
      end
      if (go_s) begin
        chan_sel_r <= ctrl[CHAN_LO +: NCHAN_LOG2];
        l_r        <= l_clamp_s;
        samp_cnt_r <= {CNT_W{1'b0}};
        avg_i_r    <= {DATA_W{1'b0}};
        avg_q_r    <= {DATA_W{1'b0}};
      end else if (acc_en_s) begin
        samp_cnt_r <= samp_cnt_r + CNT_ONE;
        if (last_s) begin
          avg_i_r <= avg_i_nxt_s;
          avg_q_r <= avg_q_nxt_s;
        end
      end
      busy_r       <= (state_nxt_s == WAIT_SYNC) || (state_nxt_s == ACCUM);
      done_r       <= (state_nxt_s == DONE);
      done_pulse_r <= (state_nxt_s == DONE) && (state_r != DONE);
    end
  end

  avg_iq_acc #(.DATA_W(DATA_W), .MAX_L(MAX_L), .SUM_W(SUM_W)) u_acc_i (
    .clk     (user_clk),
    .rst     (user_rst),
    .clr     (go_s),
    .en      (acc_en_s),
    .din     (in_i),
    .shift   (l_r),
    .avg_nxt (avg_i_nxt_s)
  );

  avg_iq_acc #(.DATA_W(DATA_W), .MAX_L(MAX_L), .SUM_W(SUM_W)) u_acc_q (
    .clk     (user_clk),
    .rst     (user_rst),
    .clr     (go_s),
    .en      (acc_en_s),
    .din     (in_q),
    .shift   (l_r),
    .avg_nxt (avg_q_nxt_s)
  );

  assign avg_i      = avg_i_r;
  assign avg_q      = avg_q_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign done_pulse = done_pulse_r;

endmodule
